// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the LUT fabric configuration path.
// Holds the default LUT/word geometry, the words-per-LUT calculation and the
// loader FSM state type.
package fabric_cfg_pkg;

  // 32 truth-table bits plus the output-register select bit (MSB).
  localparam int unsigned LUT_BITS_DEFAULT = 33;
  localparam int unsigned WORD_W_DEFAULT   = 32;

  // Words needed to cover one LUT configuration (ceiling division).
  function automatic int unsigned calc_wpl(input int unsigned lut_bits,
                                           input int unsigned word_w);
    return (lut_bits + word_w - 1) / word_w;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } cfg_state_e;

endpackage

// File: rtl/lut_shadow_slot.sv
// Shadow register for a single LUT configuration.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   wr_en          : write the selected word this cycle
//   wr_sel         : index of the word within the LUT (0 = low word)
//   wr_data        : configuration word
//   data_next      : shadow contents after this cycle's write (used for the
//                    same-edge commit of the final word)
module lut_shadow_slot #(
  parameter int unsigned LUT_BITS = 33,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned WPL      = 2,
  parameter int unsigned SEL_W    = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [LUT_BITS-1:0] data_next
);

  logic [LUT_BITS-1:0] data_q;

  for (genvar w = 0; w < WPL; w++) begin : g_word
    localparam int unsigned Lo     = w * WORD_W;
    localparam int unsigned Hi     = (Lo + WORD_W > LUT_BITS) ? LUT_BITS : Lo + WORD_W;
    localparam int unsigned SliceW = Hi - Lo;

    assign data_next[Hi-1:Lo] = (wr_en && (wr_sel == SEL_W'(w))) ? wr_data[SliceW-1:0]
                                                                  : data_q[Hi-1:Lo];

    // Bits of the last word beyond LUT_BITS are discarded by design.
    if (SliceW < WORD_W) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^wr_data[WORD_W-1:SliceW];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_next;
    end
  end

endmodule

// File: rtl/lut_config_loader.sv
// Streaming configuration loader for the LUT fabric.
// Assembles WORD_W-wide words (low word of each LUT first) into per-LUT
// shadow registers and commits the whole image atomically to cfg_mem on the
// edge that accepts the final word. The previous image stays live meanwhile.
// Ports:
//   clock, reset_n        : clock and asynchronous active-low reset
//   start                 : begin / restart a load (wins over a same-cycle accept)
//   word_valid/word_data  : word stream input; word_ready high only while loading
//   cfg_mem, cfg_valid    : committed image; cfg_valid sticks until reset
//   busy, done, lut_idx   : load in progress, commit pulse, LUT being filled
module lut_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned NUM_LUTS = 20,
  parameter int unsigned LUT_BITS = LUT_BITS_DEFAULT,
  parameter int unsigned WORD_W   = WORD_W_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         word_valid,
  input  logic [WORD_W-1:0]            word_data,
  output logic                         word_ready,
  output logic [NUM_LUTS*LUT_BITS-1:0] cfg_mem,
  output logic                         cfg_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_LUTS)-1:0]  lut_idx
);

  localparam int unsigned WPL  = calc_wpl(LUT_BITS, WORD_W);
  localparam int unsigned CntW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned IdxW = $clog2(NUM_LUTS);
  localparam int unsigned ImgW = NUM_LUTS * LUT_BITS;

  cfg_state_e      state_q, state_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [IdxW-1:0] lut_idx_q, lut_idx_d;
  logic [ImgW-1:0] cfg_mem_q;
  logic            cfg_valid_q;
  logic            accept;
  logic            commit;
  logic [ImgW-1:0] shadow_next;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lut_idx_d  = lut_idx_q;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          lut_idx_d  = '0;
        end
      end
      StLoad: begin
        if (start) begin
          // Restart: the word offered this cycle is dropped.
          word_cnt_d = '0;
          lut_idx_d  = '0;
        end else if (word_valid) begin
          accept = 1'b1;
          if (word_cnt_q == CntW'(WPL - 1)) begin
            word_cnt_d = '0;
            if (lut_idx_q == IdxW'(NUM_LUTS - 1)) begin
              lut_idx_d = '0;
              commit    = 1'b1;
              state_d   = StDone;
            end else begin
              lut_idx_d = lut_idx_q + IdxW'(1);
            end
          end else begin
            word_cnt_d = word_cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          lut_idx_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar k = 0; k < NUM_LUTS; k++) begin : g_slot
    lut_shadow_slot #(
      .LUT_BITS (LUT_BITS),
      .WORD_W   (WORD_W),
      .WPL      (WPL),
      .SEL_W    (CntW)
    ) u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en     (accept && (lut_idx_q == IdxW'(k))),
      .wr_sel    (word_cnt_q),
      .wr_data   (word_data),
      .data_next (shadow_next[k*LUT_BITS +: LUT_BITS])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      lut_idx_q   <= '0;
      cfg_mem_q   <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lut_idx_q  <= lut_idx_d;
      if (commit) begin
        // shadow_next already includes the final word accepted on this edge.
        cfg_mem_q   <= shadow_next;
        cfg_valid_q <= 1'b1;
      end
    end
  end

  assign word_ready = (state_q == StLoad);
  assign busy       = (state_q == StLoad);
  assign done       = (state_q == StDone);
  assign lut_idx    = lut_idx_q;
  assign cfg_mem    = cfg_mem_q;
  assign cfg_valid  = cfg_valid_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench for lut_config_loader with default geometry
// (20 LUTs x 33 bits, 32-bit words, 40 words per image).
module tb_lut_config_loader;

  localparam int NL  = 20;
  localparam int LB  = 33;
  localparam int WW  = 32;
  localparam int NW  = 40;
  localparam int IW  = 5;
  localparam int TOT = NL * LB;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready;
  logic [TOT-1:0] cfg_mem;
  logic          cfg_valid;
  logic          busy;
  logic          done;
  logic [IW-1:0] lut_idx;

  int vecs;
  int errs;

  logic [WW-1:0]  wbuf [NW];
  logic [TOT-1:0] live_img;
  logic           live_valid;
  logic [TOT-1:0] exp_q [$];

  lut_config_loader #(
    .NUM_LUTS (NL),
    .LUT_BITS (LB),
    .WORD_W   (WW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .cfg_mem    (cfg_mem),
    .cfg_valid  (cfg_valid),
    .busy       (busy),
    .done       (done),
    .lut_idx    (lut_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected image: LUT k = {word 2k+1, word 2k} truncated to LB bits.
  function automatic logic [TOT-1:0] model_image();
    logic [TOT-1:0]  img;
    logic [2*WW-1:0] pair;
    img = '0;
    for (int k = 0; k < NL; k++) begin
      pair = {wbuf[2*k+1], wbuf[2*k]};
      img[k*LB +: LB] = pair[LB-1:0];
    end
    return img;
  endfunction

  task automatic drive_load(input bit gaps, input bit valid_with_start);
    int sent;
    int cyc;
    logic [TOT-1:0] exp_img;
    start      = 1'b1;
    word_valid = valid_with_start;
    word_data  = 32'hDEAD_BEEF;
    step();
    start      = 1'b0;
    word_valid = 1'b0;
    cyc        = 1;
    vecs++;
    if (busy !== 1'b1 || word_ready !== 1'b1 || lut_idx !== '0) begin
      errs++;
      $display("FAIL start_entry: busy=%b ready=%b lut_idx=%0d, required 1 1 0",
               busy, word_ready, lut_idx);
    end
    exp_q.push_back(model_image());
    sent = 0;
    while (sent < NW && cyc < 400) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        word_valid = 1'b0;
      end else begin
        word_valid = 1'b1;
        word_data  = wbuf[sent];
      end
      step();
      cyc++;
      if (word_valid) sent++;
      word_valid = 1'b0;
      if (sent < NW) begin
        vecs++;
        if (cfg_mem !== live_img || cfg_valid !== live_valid || done !== 1'b0) begin
          errs++;
          $display("FAIL live_hold (word %0d): cfg_valid=%b done=%b cfg_mem=%h, required %b 0 %h",
                   sent, cfg_valid, done, cfg_mem, live_valid, live_img);
        end
      end
    end
    if (sent < NW) begin
      errs++;
      $display("FAIL load_timeout: %0d words accepted, required %0d", sent, NW);
      void'(exp_q.pop_back());
      return;
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL done_pulse: done=%b, required 1", done);
    end
    if (!gaps) begin
      vecs++;
      if (cyc != NW + 1) begin
        errs++;
        $display("FAIL load_latency: done after %0d cycles, required %0d", cyc, NW + 1);
      end
    end
    exp_img = exp_q.pop_front();
    vecs++;
    if (cfg_mem !== exp_img || cfg_valid !== 1'b1) begin
      errs++;
      $display("FAIL commit: cfg_valid=%b cfg_mem=%h, required 1 %h", cfg_valid, cfg_mem, exp_img);
    end
    live_img   = exp_img;
    live_valid = 1'b1;
    // A word offered during DONE must be ignored.
    word_valid = 1'b1;
    word_data  = 32'hFFFF_0000;
    step();
    word_valid = 1'b0;
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 || lut_idx !== '0 ||
        cfg_mem !== live_img) begin
      errs++;
      $display("FAIL done_exit: done=%b busy=%b ready=%b lut_idx=%0d, required 0 0 0 0 (mem same=%b)",
               done, busy, word_ready, lut_idx, cfg_mem === live_img);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    live_img   = '0;
    live_valid = 1'b0;
    repeat (3) step();
    vecs++;
    if (cfg_mem !== '0 || cfg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        word_ready !== 1'b0 || lut_idx !== '0) begin
      errs++;
      $display("FAIL reset_values: valid=%b busy=%b done=%b ready=%b idx=%0d mem_zero=%b, required all 0",
               cfg_valid, busy, done, word_ready, lut_idx, cfg_mem === '0);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [LB-1:0] exp_lut;
    for (int k = 0; k < NL; k++) begin
      wbuf[2*k]   = 32'hA5A5_0000 | 32'(k);
      wbuf[2*k+1] = 32'(k & 1);
    end
    drive_load(1'b0, 1'b0);
    for (int k = 0; k < NL; k += 19) begin
      exp_lut = {1'(k & 1), 32'hA5A5_0000 | 32'(k)};
      vecs++;
      if (cfg_mem[k*LB +: LB] !== exp_lut) begin
        errs++;
        $display("FAIL basic_lut%0d: got %h, required %h", k, cfg_mem[k*LB +: LB], exp_lut);
      end
    end
  endtask

  task automatic test_truncation();
    logic [LB-1:0] exp_lut1;
    for (int k = 0; k < NL; k++) begin
      wbuf[2*k]   = 32'h5A5A_0000 | (32'(k) << 4);
      wbuf[2*k+1] = 32'hFFFF_FFFF;
    end
    drive_load(1'b0, 1'b0);
    exp_lut1 = {1'b1, 32'h5A5A_0010};
    vecs++;
    if (cfg_mem[32] !== 1'b1 || cfg_mem[33] !== 1'b0) begin
      errs++;
      $display("FAIL trunc_bits: bit32=%b bit33=%b, required 1 0", cfg_mem[32], cfg_mem[33]);
    end
    vecs++;
    if (cfg_mem[LB +: LB] !== exp_lut1) begin
      errs++;
      $display("FAIL trunc_lut1: got %h, required %h", cfg_mem[LB +: LB], exp_lut1);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < NW; i++) wbuf[i] = $urandom();
    drive_load(1'b1, 1'b0);
  endtask

  task automatic test_restart();
    for (int i = 0; i < NW; i++) wbuf[i] = 32'h0BAD_0000 | 32'(i);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      word_valid = 1'b1;
      word_data  = wbuf[i];
      step();
    end
    word_valid = 1'b0;
    vecs++;
    if (lut_idx !== IW'(8) || cfg_mem !== live_img) begin
      errs++;
      $display("FAIL partial_idx: lut_idx=%0d mem_same=%b, required 8 1", lut_idx, cfg_mem === live_img);
    end
    for (int i = 0; i < NW; i++) wbuf[i] = 32'h3C00_0000 + 32'(i * 7);
    drive_load(1'b0, 1'b1);
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      word_data  = 32'h1234_5678 + 32'(i);
      step();
      vecs++;
      if (lut_idx !== '0 || done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 ||
          cfg_mem !== live_img) begin
        errs++;
        $display("FAIL idle_valid: idx=%0d done=%b busy=%b ready=%b mem_same=%b, required 0 0 0 0 1",
                 lut_idx, done, busy, word_ready, cfg_mem === live_img);
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < NW; i++) wbuf[i] = 32'h7700_0000 | 32'(i);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      word_valid = 1'b1;
      word_data  = wbuf[i];
      step();
    end
    word_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    vecs++;
    if (cfg_mem !== '0 || cfg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        word_ready !== 1'b0 || lut_idx !== '0) begin
      errs++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b ready=%b idx=%0d mem_zero=%b, required all 0",
               cfg_valid, busy, done, word_ready, lut_idx, cfg_mem === '0);
    end
    live_img   = '0;
    live_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    drive_load(1'b0, 1'b0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_truncation();
    test_gaps();
    test_restart();
    test_idle_valid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
